// File: rtl/lab_pkg.sv
// Shared definitions for the lab measurement blocks: FSM state encoding and
// default widths.
package lab_pkg;

    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } meter_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous input followed by a
// rising-edge detector. rise_o is high for one clk_i cycle per input rise.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Next state: shift the input into the chain, remember the last synced value
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-detect registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clkmeter.sv
// Frequency meter: counts rising edges of an asynchronous input over a gate
// window of GATE reference cycles, then latches the count together with
// saturation and range flags.
module clkmeter
    import lab_pkg::*;
#(
    parameter int unsigned GATE        = 100,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [CNT_W-1:0] min_i,
    input  logic [CNT_W-1:0] max_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o,
    output logic             in_range_o
);

    localparam int unsigned TMR_W = $clog2(GATE);

    logic rise;

    meter_state_e     state_q, state_d;
    logic [TMR_W-1:0] tmr_q,   tmr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sat_q,   sat_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q,   ovf_d;
    logic             inr_q,   inr_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sig_i),
        .rise_o(rise)
    );

    // Next-state logic for the measurement FSM, edge counter and result latch
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        inr_d   = inr_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_ARM;
            end
            S_ARM: begin
                cnt_d   = '0;
                sat_d   = 1'b0;
                tmr_d   = TMR_W'(GATE - 1);
                state_d = S_GATE;
            end
            S_GATE: begin
                // An edge arriving at full scale is lost: hold and flag it
                if (rise) begin
                    if (cnt_q == '1) sat_d = 1'b1;
                    else             cnt_d = cnt_q + CNT_W'(1);
                end
                if (tmr_q == '0) state_d = S_DONE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            S_DONE: begin
                count_d = cnt_q;
                ovf_d   = sat_q;
                inr_d   = (min_i <= cnt_q) && (cnt_q <= max_i);
                valid_d = 1'b1;
                state_d = cont_i ? S_ARM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // All FSM state and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            inr_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            inr_q   <= inr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign count_o    = count_q;
    assign ovf_o      = ovf_q;
    assign in_range_o = inr_q;

endmodule
